// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// FETCH_JUMP_PREDECODE_EN enables jump predecode in pc_next_calc.
package fetch_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 8;

    localparam logic [1:0] OPC_JUMP = 2'b11;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               valid;
        logic               pred_taken;
    } if_id_t;

    function automatic logic [PC_W-1:0] sext6(input logic [5:0] d);
        return {{(PC_W-6){d[5]}}, d};
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC computation; optional jump predecode under
// FETCH_JUMP_PREDECODE_EN, otherwise sequential pc+1.
module pc_next_calc
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr_code,
    output logic [PC_W-1:0]    next_pc,
    output logic               pred_taken
);

`ifdef FETCH_JUMP_PREDECODE_EN
    logic is_jump;

    assign is_jump = (instr_code[7:6] == OPC_JUMP);

    always_comb begin
        next_pc    = pc + PC_W'(1);
        pred_taken = 1'b0;
        if (is_jump) begin
            next_pc    = pc + sext6(instr_code[5:0]);
            pred_taken = 1'b1;
        end
    end
`else
    logic unused_instr;

    assign unused_instr = ^instr_code;
    assign next_pc      = pc + PC_W'(1);
    assign pred_taken   = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-stage instruction fetch with FETCH/HALT FSM and IF/ID register.
// Jump predecode is selected by FETCH_JUMP_PREDECODE_EN.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 8'h00,
    parameter int              MEM_DEPTH = 6
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr_code,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic               if_id_pred_taken,
    output logic               halted
);

    localparam logic [PC_W:0] DEPTH9 = (PC_W+1)'(MEM_DEPTH);

    if (MEM_DEPTH < 1 || MEM_DEPTH > 256) begin : g_bad_depth
        $error("instr_fetch_unit: MEM_DEPTH out of range 1..256");
    end

    if ({1'b0, RESET_PC} >= DEPTH9) begin : g_bad_reset_pc
        $error("instr_fetch_unit: RESET_PC must be below MEM_DEPTH");
    end

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    if_id_t          ifid_q, ifid_d;
    logic [PC_W-1:0] calc_pc;
    logic            calc_taken;

    function automatic logic in_range(input logic [PC_W-1:0] a);
        return ({1'b0, a} < DEPTH9);
    endfunction

    pc_next_calc u_pc_next_calc (
        .pc         (pc_q),
        .instr_code (instr_code),
        .next_pc    (calc_pc),
        .pred_taken (calc_taken)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ifid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
        end
    end

    // Priority: redirect > stall > halt hold > normal fetch
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        if (redirect) begin
            pc_d              = redirect_pc;
            ifid_d.valid      = 1'b0;
            ifid_d.pred_taken = 1'b0;
            state_d           = in_range(redirect_pc) ? FETCH : HALT;
        end else if (!stall) begin
            unique case (state_q)
                HALT: begin
                    ifid_d.valid = 1'b0;
                end
                FETCH: begin
                    ifid_d.instr      = instr_code;
                    ifid_d.pc         = pc_q;
                    ifid_d.valid      = 1'b1;
                    ifid_d.pred_taken = calc_taken;
                    pc_d              = calc_pc;
                    state_d           = in_range(calc_pc) ? FETCH : HALT;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    assign pc               = pc_q;
    assign if_id_instr      = ifid_q.instr;
    assign if_id_pc         = ifid_q.pc;
    assign if_id_valid      = ifid_q.valid;
    assign if_id_pred_taken = ifid_q.pred_taken;
    assign halted           = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a cycle reference model.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pc;
    logic [7:0] instr_code;
    logic       stall;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic [7:0] if_id_instr;
    logic [7:0] if_id_pc;
    logic       if_id_valid;
    logic       if_id_pred_taken;
    logic       halted;

    int tests = 0;
    int fails = 0;

    localparam int DEPTH = 6;
    logic [7:0] mem [DEPTH] = '{8'h13, 8'h51, 8'h0A, 8'hC5, 8'h4B, 8'h3C};

`ifdef FETCH_JUMP_PREDECODE_EN
    localparam logic [7:0] EXP_PC_C5   = 8'h08;
    localparam logic       EXP_PRED_C5 = 1'b1;
    localparam logic       EXP_HALT_C5 = 1'b1;
    localparam logic [7:0] EXP_LAST_PC = 8'h03;
    localparam logic [7:0] EXP_HALT_PC = 8'h08;
`else
    localparam logic [7:0] EXP_PC_C5   = 8'h04;
    localparam logic       EXP_PRED_C5 = 1'b0;
    localparam logic       EXP_HALT_C5 = 1'b0;
    localparam logic [7:0] EXP_LAST_PC = 8'h05;
    localparam logic [7:0] EXP_HALT_PC = 8'h06;
`endif

    always #5 clk = ~clk;

    assign instr_code = (int'(pc) < DEPTH) ? mem[pc] : 8'h00;

    instr_fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .pc               (pc),
        .instr_code       (instr_code),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .if_id_instr      (if_id_instr),
        .if_id_pc         (if_id_pc),
        .if_id_valid      (if_id_valid),
        .if_id_pred_taken (if_id_pred_taken),
        .halted           (halted)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural rules evaluated per clock
    logic       m_live = 1'b0;
    logic [7:0] m_pc, m_instr, m_ifpc;
    logic       m_valid, m_pred, m_halt;

    function automatic logic [8:0] model_next(input logic [7:0] p);
        logic [7:0] op;
        op = (int'(p) < DEPTH) ? mem[p] : 8'h00;
`ifdef FETCH_JUMP_PREDECODE_EN
        if (op[7:6] == 2'b11)
            return {1'b1, p + {{2{op[5]}}, op[5:0]}};
`endif
        return {1'b0, p + 8'd1};
    endfunction

    always @(posedge clk) begin
        logic [8:0] n;
        n = model_next(m_pc);
        if (!reset) begin
            m_live  <= 1'b1;
            m_pc    <= 8'h00;
            m_instr <= 8'h00;
            m_ifpc  <= 8'h00;
            m_valid <= 1'b0;
            m_pred  <= 1'b0;
            m_halt  <= 1'b0;
        end else if (redirect) begin
            m_pc    <= redirect_pc;
            m_valid <= 1'b0;
            m_pred  <= 1'b0;
            m_halt  <= int'(redirect_pc) >= DEPTH;
        end else if (stall) begin
            m_pc <= m_pc;
        end else if (m_halt) begin
            m_valid <= 1'b0;
        end else begin
            m_instr <= (int'(m_pc) < DEPTH) ? mem[m_pc] : 8'h00;
            m_ifpc  <= m_pc;
            m_valid <= 1'b1;
            m_pred  <= n[8];
            m_pc    <= n[7:0];
            m_halt  <= int'(n[7:0]) >= DEPTH;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model_pc", pc, m_pc);
            check("model_halted", halted, m_halt);
            check("model_valid", if_id_valid, m_valid);
            check("model_pred", if_id_pred_taken, m_pred);
            if (m_valid) begin
                check("model_instr", if_id_instr, m_instr);
                check("model_ifpc", if_id_pc, m_ifpc);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        cyc(2);
        check("rst_pc", pc, 8'h00);
        check("rst_valid", if_id_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_instr", if_id_instr, 8'h00);

        reset = 1'b1;
        cyc(1);
        check("f0_ifpc", if_id_pc, 8'h00);
        check("f0_instr", if_id_instr, 8'h13);
        check("f0_valid", if_id_valid, 1);
        check("f0_pc", pc, 8'h01);
        cyc(1);
        check("f1_instr", if_id_instr, 8'h51);

        stall = 1'b1;
        cyc(3);
        check("stall_pc", pc, 8'h02);
        check("stall_instr", if_id_instr, 8'h51);
        check("stall_ifpc", if_id_pc, 8'h01);
        stall = 1'b0;
        cyc(1);
        check("resume_ifpc", if_id_pc, 8'h02);
        cyc(1);
        check("c5_ifpc", if_id_pc, 8'h03);
        check("c5_pc", pc, EXP_PC_C5);
        check("c5_pred", if_id_pred_taken, EXP_PRED_C5);
        check("c5_halt", halted, EXP_HALT_C5);
        cyc(3);
        check("end_halted", halted, 1);
        check("end_valid", if_id_valid, 0);
        check("end_ifpc", if_id_pc, EXP_LAST_PC);
        check("end_pc", pc, EXP_HALT_PC);

        redirect    = 1'b1;
        redirect_pc = 8'h01;
        cyc(1);
        redirect = 1'b0;
        check("rd1_valid", if_id_valid, 0);
        check("rd1_halted", halted, 0);
        check("rd1_pc", pc, 8'h01);
        cyc(1);
        check("rd1_ifpc", if_id_pc, 8'h01);
        check("rd1_cap", if_id_valid, 1);

        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 8'h07;
        cyc(1);
        redirect = 1'b0;
        stall    = 1'b0;
        check("rd7_pc", pc, 8'h07);
        check("rd7_halted", halted, 1);
        check("rd7_valid", if_id_valid, 0);
        cyc(2);
        check("rd7_hold", pc, 8'h07);

        redirect    = 1'b1;
        redirect_pc = 8'hFF;
        cyc(1);
        redirect = 1'b0;
        check("rdff_halted", halted, 1);

        redirect    = 1'b1;
        redirect_pc = 8'h00;
        cyc(1);
        redirect = 1'b0;
        cyc(2);
        stall = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        check("rst2_pc", pc, 8'h00);
        check("rst2_valid", if_id_valid, 0);
        check("rst2_ifpc", if_id_pc, 8'h00);
        check("rst2_instr", if_id_instr, 8'h00);
        check("rst2_halted", halted, 0);
        reset = 1'b1;
        stall = 1'b0;
        cyc(1);
        check("rst2_first", if_id_valid, 1);
        check("rst2_first_pc", if_id_pc, 8'h00);
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
